// File: rtl/tri_test_seq_if.sv
// Bus for the point-in-triangle sequencer: coordinate entry in, result flags out.
interface tri_test_seq_if #(
  parameter int unsigned W = 10
);
  logic [W-1:0] px;
  logic [W-1:0] py;
  logic         sel_ponto;
  logic         ledg;
  logic         valid;
  logic         busy;
  logic [1:0]   pt_cnt;
  logic         degen;

  modport master (
    output px, py, sel_ponto,
    input  ledg, valid, busy, pt_cnt, degen
  );

  modport slave (
    input  px, py, sel_ponto,
    output ledg, valid, busy, pt_cnt, degen
  );
endinterface

// File: rtl/tri_test_seq.sv
// Point-in-triangle sequencer. Captures P1, P2, P3 and PT on rising edges of
// sel_ponto, then runs one shared cross-product unit over the three edges and
// reports inside/on-boundary on ledg.
// Optional: define TRI_DEGEN_CHECK_EN to add a fourth step, sign(P1,P2,P3), that
// flags a collinear (degenerate) triangle on degen and forces ledg low.
module tri_test_seq #(
  parameter int unsigned W = 10
) (
  input  logic           clk,
  input  logic           rst,
  tri_test_seq_if.slave  tri_bus
);
  localparam int unsigned PW = 2 * W + 2;
  localparam int unsigned SW = 2 * W + 3;
`ifdef TRI_DEGEN_CHECK_EN
  localparam logic [1:0] LastStep = 2'd3;
`else
  localparam logic [1:0] LastStep = 2'd2;
`endif

  // StFin is the cycle between the last sign step and the result becoming visible
  typedef enum logic [1:0] {StCap, StCalc, StFin, StDone} state_t;

  state_t       r_state, w_state_d;
  logic [1:0]   r_step, w_step_d;
  logic [1:0]   r_pt_cnt, w_pt_cnt_d;
  logic         r_sel_q;
  logic         r_busy, w_busy_d;
  logic         r_valid, w_valid_d;
  logic         r_ledg, w_ledg_d;
  logic         r_neg, w_neg_d;
  logic         r_pos, w_pos_d;
  // Index 0..3 = P1, P2, P3, PT
  logic [W-1:0] r_px [4];
  logic [W-1:0] r_py [4];
`ifdef TRI_DEGEN_CHECK_EN
  logic         r_zero, w_zero_d;
  logic         r_degen, w_degen_d;
`endif

  logic              w_cap, w_we;
  logic [W-1:0]      w_ax, w_ay, w_bx, w_by, w_cx, w_cy;
  logic signed [W:0] w_dax, w_day, w_dbx, w_dby;
  logic signed [PW-1:0] w_prod_l, w_prod_r;
  logic signed [SW-1:0] w_d;
  logic              w_d_neg, w_d_pos;

  assign w_cap = tri_bus.sel_ponto & ~r_sel_q;

  // Operand select for the shared sign unit
  always_comb begin
    w_ax = r_px[3];
    w_ay = r_py[3];
    w_bx = r_px[0];
    w_by = r_py[0];
    w_cx = r_px[1];
    w_cy = r_py[1];
    unique case (r_step)
      2'd0: ;
      2'd1: begin
        w_bx = r_px[1]; w_by = r_py[1];
        w_cx = r_px[2]; w_cy = r_py[2];
      end
      2'd2: begin
        w_bx = r_px[2]; w_by = r_py[2];
        w_cx = r_px[0]; w_cy = r_py[0];
      end
      default: begin
        w_ax = r_px[0]; w_ay = r_py[0];
        w_bx = r_px[1]; w_by = r_py[1];
        w_cx = r_px[2]; w_cy = r_py[2];
      end
    endcase
  end

  // Zero-extended differences fit W+1 signed bits; products and sum cannot overflow
  assign w_dax    = $signed({1'b0, w_ax}) - $signed({1'b0, w_cx});
  assign w_day    = $signed({1'b0, w_ay}) - $signed({1'b0, w_cy});
  assign w_dbx    = $signed({1'b0, w_bx}) - $signed({1'b0, w_cx});
  assign w_dby    = $signed({1'b0, w_by}) - $signed({1'b0, w_cy});
  assign w_prod_l = PW'(w_dax) * PW'(w_dby);
  assign w_prod_r = PW'(w_dbx) * PW'(w_day);
  assign w_d      = SW'(w_prod_l) - SW'(w_prod_r);
  assign w_d_neg  = w_d[SW-1];
  assign w_d_pos  = ~w_d[SW-1] & (|w_d);

  // Next-state and output-register logic
  always_comb begin
    w_state_d  = r_state;
    w_step_d   = r_step;
    w_pt_cnt_d = r_pt_cnt;
    w_busy_d   = r_busy;
    w_valid_d  = r_valid;
    w_ledg_d   = r_ledg;
    w_neg_d    = r_neg;
    w_pos_d    = r_pos;
    w_we       = 1'b0;
`ifdef TRI_DEGEN_CHECK_EN
    w_zero_d   = r_zero;
    w_degen_d  = r_degen;
`endif
    unique case (r_state)
      StCap: begin
        if (w_cap) begin
          w_we = 1'b1;
          if (r_pt_cnt == 2'd3) begin
            w_state_d  = StCalc;
            w_step_d   = 2'd0;
            w_busy_d   = 1'b1;
            w_neg_d    = 1'b0;
            w_pos_d    = 1'b0;
            w_pt_cnt_d = 2'd0;
`ifdef TRI_DEGEN_CHECK_EN
            w_zero_d   = 1'b0;
`endif
          end else begin
            w_pt_cnt_d = r_pt_cnt + 2'd1;
          end
        end
      end
      StCalc: begin
`ifdef TRI_DEGEN_CHECK_EN
        if (r_step == 2'd3) begin
          w_zero_d = (w_d == '0);
        end else begin
          w_neg_d = r_neg | w_d_neg;
          w_pos_d = r_pos | w_d_pos;
        end
`else
        w_neg_d = r_neg | w_d_neg;
        w_pos_d = r_pos | w_d_pos;
`endif
        if (r_step == LastStep) begin
          w_state_d = StFin;
          w_busy_d  = 1'b0;
        end else begin
          w_step_d = r_step + 2'd1;
        end
      end
      StFin: begin
        w_state_d = StDone;
        w_valid_d = 1'b1;
`ifdef TRI_DEGEN_CHECK_EN
        w_ledg_d  = ~(r_neg & r_pos) & ~r_zero;
        w_degen_d = r_zero;
`else
        w_ledg_d  = ~(r_neg & r_pos);
`endif
      end
      StDone: begin
        // New capture starts the next set with P1 (pt_cnt is 0 here)
        if (w_cap) begin
          w_we       = 1'b1;
          w_state_d  = StCap;
          w_pt_cnt_d = 2'd1;
          w_valid_d  = 1'b0;
          w_ledg_d   = 1'b0;
`ifdef TRI_DEGEN_CHECK_EN
          w_degen_d  = 1'b0;
`endif
        end
      end
      default: w_state_d = StCap;
    endcase
  end

  // State, flags and point storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StCap;
      r_step   <= 2'd0;
      r_pt_cnt <= 2'd0;
      r_sel_q  <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_ledg   <= 1'b0;
      r_neg    <= 1'b0;
      r_pos    <= 1'b0;
`ifdef TRI_DEGEN_CHECK_EN
      r_zero   <= 1'b0;
      r_degen  <= 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
      end
    end else begin
      r_state  <= w_state_d;
      r_step   <= w_step_d;
      r_pt_cnt <= w_pt_cnt_d;
      r_sel_q  <= tri_bus.sel_ponto;
      r_busy   <= w_busy_d;
      r_valid  <= w_valid_d;
      r_ledg   <= w_ledg_d;
      r_neg    <= w_neg_d;
      r_pos    <= w_pos_d;
`ifdef TRI_DEGEN_CHECK_EN
      r_zero   <= w_zero_d;
      r_degen  <= w_degen_d;
`endif
      if (w_we) begin
        r_px[r_pt_cnt] <= tri_bus.px;
        r_py[r_pt_cnt] <= tri_bus.py;
      end
    end
  end

  assign tri_bus.ledg   = r_ledg;
  assign tri_bus.valid  = r_valid;
  assign tri_bus.busy   = r_busy;
  assign tri_bus.pt_cnt = r_pt_cnt;
`ifdef TRI_DEGEN_CHECK_EN
  assign tri_bus.degen  = r_degen;
`else
  assign tri_bus.degen  = 1'b0;
`endif
endmodule
